instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the RISC-V core, sitting between the instruction memory (preloaded from the firmware hex image) and the decode stage. It maintains the PC and issues sequential word fetches to a fixed-latency synchronous instruction memory. It buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake. Redirects from execute (branches and jumps) flush all buffered and in-flight fetches and restart fetching at the new PC.

## Interface
- CPU_WIDTH, 32, width of PC and instruction words
- RAM_WIDTH, 31, width of instruction-memory byte address
- RESET_PC, 0, PC loaded on reset; bits [1:0] must be 0
- FIFO_DEPTH, 4, fetch buffer entries; power of two, ≥2

- clk  in  1  core clock; all state updates on rising edge
- a_reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  RAM_WIDTH  byte address of the fetch, equal to pc[RAM_WIDTH-1:0]
- imem_rdata  in  CPU_WIDTH  instruction word; valid exactly one cycle after the imem_req cycle
- redirect_valid  in  1  execute requests a PC change
- redirect_pc  in  CPU_WIDTH  target PC; bits [1:0] are ignored and treated as 0
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts this cycle
- out_instr  out  CPU_WIDTH  instruction at FIFO head
- out_pc  out  CPU_WIDTH  PC of out_instr

## Operation
- **State:**
  - pc register.
  - FIFO of {pc, instr} with count 0..FIFO_DEPTH.
  - inflight flag holding the previous cycle's imem_req.
  - inflight_pc holding the address of that request.
- **Issue rule:** imem_req = !redirect_valid && (count + inflight < FIFO_DEPTH). On issue, pc ← pc + 4, wrapping modulo 2^CPU_WIDTH.
- **Response:** when inflight=1 and redirect_valid=0, {inflight_pc, imem_rdata} is pushed into the FIFO. The issue rule guarantees a free slot, so overflow is impossible. If redirect_valid=1, the response is discarded.
- **Output:**
  - out_valid = (count≠0) && !redirect_valid. This is a combinational gate on redirect.
  - out_instr and out_pc are the FIFO head.
  - Pop occurs when out_valid && out_ready.
- **Simultaneous push and pop:** count is unchanged. Push into an empty FIFO becomes visible the next cycle, with no bypass.
- **Redirect (cycle R):**
  - FIFO flushed: count ← 0.
  - In-flight response dropped.
  - No request issued in R.
  - pc ← {redirect_pc[CPU_WIDTH-1:2], 2'b00}.
  - inflight ← 0.
  - A pop attempt in R is ignored, because out_valid is 0.
- **Back-to-back redirects:** the last one wins. Each redirect cycle suppresses issue and discards the response.
- **Stall:** with out_ready=0 the FIFO fills and issue stops when count + inflight = FIFO_DEPTH. Issue resumes the cycle after the first pop frees space.
- **Reset (async, any time):**
  - pc ← RESET_PC.
  - count ← 0; FIFO pointers cleared.
  - inflight ← 0.
  - A memory response arriving after reset is ignored.

## Timing
- **Reset values:**
  - imem_req=0 while a_reset_n=0.
  - imem_addr=RESET_PC[RAM_WIDTH-1:0].
  - out_valid=0.
  - out_instr and out_pc=0, since the FIFO storage is reset.
- **Latency:** request in cycle N → response captured at the end of N+1 → out_valid=1 in cycle N+2.
- **Start-up:** first request is in the first cycle after reset deassertion (cycle 0). The first instruction is presented in cycle 2.
- **Throughput:** with out_ready held 1, one instruction per cycle is sustained from cycle 2 onward.
- **Redirect:** redirect in R → first request to the target in R+1 → target instruction presented in R+3. out_valid=0 in R, R+1 and R+2.
- **Full FIFO:** the FIFO never exceeds FIFO_DEPTH entries. imem_req is low whenever count + inflight = FIFO_DEPTH.

## Test plan
- **Reset and stream:**
  - Stimulus: memory returns word = address ^ 32'hA5A5_0000; reset released; out_ready=1.
  - Required: out_pc sequence 0,4,8,… starting cycle 2, one per cycle; out_instr matches.
- **Backpressure:**
  - Stimulus: out_ready=0 for 10 cycles, then 1.
  - Required: exactly 4 entries buffered (PCs 0..12); imem_req low while full; no lost or duplicated PCs after release.
- **Redirect mid-stream:**
  - Stimulus: redirect_valid=1 with redirect_pc=0x100 in cycle 6.
  - Required: out_valid=0 in cycles 6–8; cycle 9 presents pc 0x100, then 0x104; no pre-redirect PC appears after cycle 5.
- **Redirect with pop and misaligned target:**
  - Stimulus: out_ready=1 with redirect_pc=0x203 in the same cycle.
  - Required: no pop counted; the next presented pc is 0x200.
- **Wrap-around:**
  - Stimulus: redirect to 0xFFFF_FFF8.
  - Required: presented PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Reset mid-operation:**
  - Stimulus: assert a_reset_n=0 asynchronously between clock edges while the FIFO holds 3 entries.
  - Required: out_valid drops immediately; after release the stream restarts at RESET_PC with no stale entries.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, fixed-latency imem requests,
// and a small {pc, instr} buffer handed to decode over valid/ready.
module instr_fetch #(
  parameter int CPU_WIDTH = 32,
  parameter int RAM_WIDTH = 31,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 a_reset_n,
  output logic                 imem_req,
  output logic [RAM_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] out_instr,
  output logic [CPU_WIDTH-1:0] out_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [CPU_WIDTH-1:0] ipc_q, ipc_d;
  logic                 inflight_q, inflight_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW-1:0]        wr_q, wr_d;
  logic [CPU_WIDTH-1:0] fpc_q   [FIFO_DEPTH];
  logic [CPU_WIDTH-1:0] finstr_q [FIFO_DEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic [AW:0] occ;

  // Occupancy counts the in-flight word so a returning response always fits.
  assign occ   = cnt_q + {{AW{1'b0}}, inflight_q};
  assign issue = a_reset_n && !redirect_valid && (occ < DEPTH);
  assign push  = inflight_q && !redirect_valid;
  assign pop   = out_valid && out_ready;

  assign imem_req  = issue;
  assign imem_addr = pc_q[RAM_WIDTH-1:0];
  assign out_valid = (cnt_q != '0) && !redirect_valid;
  assign out_instr = finstr_q[rd_q];
  assign out_pc    = fpc_q[rd_q];

  always_comb begin
    pc_d       = pc_q;
    ipc_d      = pc_q;
    inflight_d = issue;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
      inflight_d = 1'b0;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (issue) pc_d = pc_q + CPU_WIDTH'(4);
      if (push)  wr_d = wr_q + 1'b1;
      if (pop)   rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fpc_q[i]    <= '0;
        finstr_q[i] <= '0;
      end
    end else if (push) begin
      fpc_q[wr_q]    <= ipc_q;
      finstr_q[wr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a timestamped queue model
// of issued-but-not-consumed fetches.
module tb_instr_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        a_reset_n = 1'b0;
  logic        imem_req;
  logic [30:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_fetch #(
    .CPU_WIDTH (32),
    .RAM_WIDTH (31),
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .a_reset_n     (a_reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {1'b0, a[30:0]} ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk)
    if (imem_req) imem_rdata <= word({1'b0, imem_addr});

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] ipc;
  int          now;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rpc,
                     input logic rdy);
    logic er, ev;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    er = !rv && (q.size() < DEPTH);
    ev = !rv && (q.size() > 0) && (q[0].cyc + 2 <= now);
    chk("imem_req", imem_req, er);
    chk("out_valid", out_valid, ev);
    if (er) chk("imem_addr", imem_addr, ipc[30:0]);
    if (ev) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, word(q[0].pc));
    end
    if (rv) begin
      q.delete();
      ipc = rpc & ~32'h3;
    end else begin
      if (ev && rdy) void'(q.pop_front());
      if (er) begin
        q.push_back('{now, ipc});
        ipc = ipc + 32'd4;
      end
    end
    now++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    a_reset_n      = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_imem_addr", imem_addr, 31'h0);
    repeat (2) @(posedge clk);
    #2;
    a_reset_n = 1'b1;
    q.delete();
    ipc = 32'h0;
    now = 0;
  endtask

  initial begin
    do_reset();
    // stream, then backpressure
    repeat (12) cyc(1'b0, '0, 1'b1);
    repeat (10) cyc(1'b0, '0, 1'b0);
    repeat (10) cyc(1'b0, '0, 1'b1);

    // redirect in cycle 6 after a fresh reset
    do_reset();
    repeat (6) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 32'h100, 1'b1);
    repeat (8) cyc(1'b0, '0, 1'b1);

    // redirect coinciding with a pop, misaligned target
    cyc(1'b1, 32'h203, 1'b1);
    repeat (6) cyc(1'b0, '0, 1'b1);

    // wrap-around past the top of the address space
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (8) cyc(1'b0, '0, 1'b1);

    // back-to-back redirects, last one wins
    cyc(1'b1, 32'h400, 1'b1);
    cyc(1'b1, 32'h808, 1'b1);
    repeat (6) cyc(1'b0, '0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(15) == 0);
      rpc = $urandom;
      cyc(rv, rpc, 1'($urandom_range(1)));
    end

    // reset while three entries are buffered
    do_reset();
    repeat (4) cyc(1'b0, '0, 1'b0);
    do_reset();
    repeat (10) cyc(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
